hood_mode_scheduler: RTL

Mode sequencer for the range-hood fan. Sits downstream of the gesture/key power controller: takes its `power_on` level plus debounced single-cycle menu/mode key pulses, and sequences the hood through standby, menu, fan levels 1–3 and self-clean. It owns the timed modes: one-shot hurricane level 3, the forced run-on when leaving level 3, and the self-clean cycle. All outputs are registered.

---
 rtl/hood_pkg.sv | 31 +++
 rtl/sec_countdown.sv | 42 ++++
 rtl/hood_mode_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hood_pkg.sv
// rtl/hood_pkg.sv - shared state encodings, fan levels and seconds width for the hood scheduler
package hood_pkg;

    localparam int SEC_W = 8;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STANDBY = 3'd1,
        ST_MENU    = 3'd2,
        ST_L1      = 3'd3,
        ST_L2      = 3'd4,
        ST_L3      = 3'd5,
        ST_L3_EXIT = 3'd6,
        ST_CLEAN   = 3'd7
    } mode_t;

    localparam logic [1:0] FAN_OFF  = 2'd0;
    localparam logic [1:0] FAN_LOW  = 2'd1;
    localparam logic [1:0] FAN_MID  = 2'd2;
    localparam logic [1:0] FAN_HIGH = 2'd3;

    function automatic logic [1:0] fan_of(mode_t m);
        case (m)
            ST_L1:               fan_of = FAN_LOW;
            ST_L2:               fan_of = FAN_MID;
            ST_L3, ST_L3_EXIT:   fan_of = FAN_HIGH;
            default:             fan_of = FAN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// rtl/sec_countdown.sv - prescaler plus seconds down-counter shared by all timed modes
module sec_countdown
    import hood_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    output logic [SEC_W-1:0] sec,
    output logic             expire
);

    localparam int PW = $clog2(TICKS_PER_SEC);

    logic [PW-1:0] pre;
    logic          tick;

    // expire is combinational so the owner can leave the state on the same edge
    assign tick   = (sec != '0) && (pre == PW'(TICKS_PER_SEC - 1));
    assign expire = tick && (sec == SEC_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pre <= '0;
            sec <= '0;
        end else if (load) begin
            pre <= '0;
            sec <= load_val;
        end else if (sec != '0) begin
            if (tick) begin
                pre <= '0;
                sec <= sec - SEC_W'(1);
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: rtl/hood_mode_scheduler.sv
// rtl/hood_mode_scheduler.sv - range-hood fan mode sequencer; self-clean built only with HOOD_SCHED_CLEAN_EN
module hood_mode_scheduler
    import hood_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int HURRICANE_SEC = 60,
    parameter int EXIT_SEC      = 60,
    parameter int CLEAN_SEC     = 180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             power_on,
    input  logic             menu_key,
    input  logic             lvl1_key,
    input  logic             lvl2_key,
    input  logic             lvl3_key,
    input  logic             clean_key,
    output logic [2:0]       mode,
    output logic [1:0]       fan_level,
    output logic             clean_active,
    output logic [SEC_W-1:0] sec_remaining,
    output logic             hurricane_used,
    output logic             clean_done
);

    mode_t            state;
    mode_t            nxt;
    logic             load;
    logic [SEC_W-1:0] load_val;
    logic             expire;
`ifdef HOOD_SCHED_CLEAN_EN
    logic             done_nxt;
`endif

    sec_countdown #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!power_on),
        .load     (load),
        .load_val (load_val),
        .sec      (sec_remaining),
        .expire   (expire)
    );

    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = '0;
`ifdef HOOD_SCHED_CLEAN_EN
        done_nxt = 1'b0;
`endif
        if (!power_on) begin
            nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:     nxt = ST_STANDBY;
                ST_STANDBY: if (menu_key) nxt = ST_MENU;
                ST_MENU: begin
                    if (menu_key)      nxt = ST_STANDBY;
                    else if (lvl1_key) nxt = ST_L1;
                    else if (lvl2_key) nxt = ST_L2;
                    else if (lvl3_key && !hurricane_used) begin
                        nxt      = ST_L3;
                        load     = 1'b1;
                        load_val = SEC_W'(HURRICANE_SEC);
                    end
`ifdef HOOD_SCHED_CLEAN_EN
                    else if (clean_key) begin
                        nxt      = ST_CLEAN;
                        load     = 1'b1;
                        load_val = SEC_W'(CLEAN_SEC);
                    end
`endif
                end
                ST_L1: begin
                    if (menu_key)      nxt = ST_STANDBY;
                    else if (lvl2_key) nxt = ST_L2;
                end
                ST_L2: begin
                    if (menu_key)      nxt = ST_STANDBY;
                    else if (lvl1_key) nxt = ST_L1;
                end
                // expiry takes precedence over a simultaneous menu press
                ST_L3: begin
                    if (expire) nxt = ST_L2;
                    else if (menu_key) begin
                        nxt      = ST_L3_EXIT;
                        load     = 1'b1;
                        load_val = SEC_W'(EXIT_SEC);
                    end
                end
                ST_L3_EXIT: if (expire) nxt = ST_STANDBY;
`ifdef HOOD_SCHED_CLEAN_EN
                ST_CLEAN: begin
                    if (expire) begin
                        nxt      = ST_STANDBY;
                        done_nxt = 1'b1;
                    end
                end
`endif
                default:    nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_OFF;
            fan_level      <= FAN_OFF;
            hurricane_used <= 1'b0;
        end else begin
            state     <= nxt;
            fan_level <= fan_of(nxt);
            if (!power_on)
                hurricane_used <= 1'b0;
            else if (state == ST_MENU && nxt == ST_L3)
                hurricane_used <= 1'b1;
        end
    end

`ifdef HOOD_SCHED_CLEAN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            clean_active <= 1'b0;
            clean_done   <= 1'b0;
        end else begin
            clean_active <= (nxt == ST_CLEAN);
            clean_done   <= done_nxt;
        end
    end
`else
    logic unused_clean;
    assign unused_clean = clean_key ^ CLEAN_SEC[0];
    assign clean_active = 1'b0;
    assign clean_done   = 1'b0;
`endif

    assign mode = state;

endmodule
